// File: rtl/uop_pkg.sv
// Shared decode/dispatch types: queue sizing, the uop record, and queue pointer/count types.
// Pure declarations; no logic.
package uop_pkg;

  localparam int INSTR_Q_DEPTH = 32;
  localparam int INSTR_Q_WIDTH = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] insn;
  } uop_insn;

  typedef logic [$clog2(INSTR_Q_DEPTH)-1:0]   qptr_t;
  typedef logic [$clog2(INSTR_Q_DEPTH+1)-1:0] qcnt_t;

endpackage

// File: rtl/uop_compact.sv
// Prefix-sum over lane valids: slot offset of each lane among the valid lanes, plus the total.
// Purely combinational, zero latency; no flow control of its own.
module uop_compact
  import uop_pkg::*;
#(
  parameter  int WIDTH = INSTR_Q_WIDTH,
  localparam int NW    = $clog2(WIDTH+1)
) (
  input  logic [WIDTH-1:0]         valid,
  output logic [WIDTH-1:0][NW-1:0] slot_off,
  output logic [NW-1:0]            n_valid
);

  logic [NW-1:0] acc;

  always_comb begin
    acc      = '0;
    slot_off = '0;
    for (int i = 0; i < WIDTH; i++) begin
      slot_off[i] = acc;
      acc         = acc + NW'(valid[i]);
    end
    n_valid = acc;
  end

endmodule

// File: rtl/uop_queue.sv
// Decode-to-dispatch uop FIFO: up to WIDTH in/out per cycle, program order, flushable; 1-cycle latency.
// Accepts only whole-group space (registered count); decode holds inputs while enq_ready_out is low.
module uop_queue
  import uop_pkg::*;
#(
  parameter  int DEPTH = INSTR_Q_DEPTH,
  parameter  int WIDTH = INSTR_Q_WIDTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH+1),
  localparam int NUM_W = $clog2(WIDTH+1)
) (
  input  logic                   clk_in,
  input  logic                   rst_N_in,
  input  logic                   flush_in,
  input  logic [WIDTH-1:0]       enq_valid_in,
  input  uop_insn [WIDTH-1:0]    enq_uop_in,
  output logic                   enq_ready_out,
  output uop_insn [WIDTH-1:0]    deq_uop_out,
  output logic [WIDTH-1:0]       deq_valid_out,
  input  logic [NUM_W-1:0]       deq_num_in,
  output logic [CNT_W-1:0]       count_out,
  output logic                   empty_out,
  output logic                   full_out
);

  uop_insn                    mem [DEPTH];
  logic [PTR_W-1:0]           head, tail;
  logic [CNT_W-1:0]           count;
  logic [WIDTH-1:0][NUM_W-1:0] slot_off;
  logic [NUM_W-1:0]           n_enq;
  logic                       enq_fire;
  logic [CNT_W-1:0]           n_enq_eff, n_deq;

  uop_compact #(.WIDTH(WIDTH)) u_compact (
    .valid    (enq_valid_in),
    .slot_off (slot_off),
    .n_valid  (n_enq)
  );

  // Ready looks only at registered count so dequeue never feeds back into decode.
  assign enq_ready_out = (count <= CNT_W'(DEPTH - WIDTH));
  assign enq_fire      = enq_ready_out && (|enq_valid_in) && !flush_in;
  assign n_enq_eff     = enq_fire ? CNT_W'(n_enq) : '0;
  assign n_deq         = (CNT_W'(deq_num_in) > count) ? count : CNT_W'(deq_num_in);

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_deq);
      tail  <= tail + PTR_W'(n_enq_eff);
      count <= count + n_enq_eff - n_deq;
    end
  end

  // Storage is intentionally unreset; valid bits come from count alone.
  always_ff @(posedge clk_in) begin
    if (enq_fire) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (enq_valid_in[i]) mem[tail + PTR_W'(slot_off[i])] <= enq_uop_in[i];
      end
    end
  end

  always_comb begin
    deq_uop_out   = '0;
    deq_valid_out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      deq_uop_out[i]   = mem[head + PTR_W'(i)];
      deq_valid_out[i] = (count > CNT_W'(i));
    end
  end

  assign count_out = count;
  assign empty_out = (count == '0);
  assign full_out  = (count == CNT_W'(DEPTH));

  always_ff @(posedge clk_in) begin
    if (rst_N_in) begin
      assert (CNT_W'(deq_num_in) <= count)
        else $error("uop_queue: deq_num_in %0d exceeds occupancy %0d", deq_num_in, count);
    end
  end

endmodule

// File: tb/tb_uop_queue.sv
// Scoreboarded bench for uop_queue: a plain uop queue models contents; a negedge monitor checks and pops.
module tb_uop_queue;
  import uop_pkg::*;

  localparam int DEPTH = INSTR_Q_DEPTH;
  localparam int WIDTH = INSTR_Q_WIDTH;

  logic                clk_in = 1'b0;
  logic                rst_N_in;
  logic                flush_in;
  logic [WIDTH-1:0]    enq_valid_in;
  uop_insn [WIDTH-1:0] enq_uop_in;
  logic                enq_ready_out;
  uop_insn [WIDTH-1:0] deq_uop_out;
  logic [WIDTH-1:0]    deq_valid_out;
  logic [2:0]          deq_num_in;
  qcnt_t               count_out;
  logic                empty_out;
  logic                full_out;

  uop_queue dut (
    .clk_in        (clk_in),
    .rst_N_in      (rst_N_in),
    .flush_in      (flush_in),
    .enq_valid_in  (enq_valid_in),
    .enq_uop_in    (enq_uop_in),
    .enq_ready_out (enq_ready_out),
    .deq_uop_out   (deq_uop_out),
    .deq_valid_out (deq_valid_out),
    .deq_num_in    (deq_num_in),
    .count_out     (count_out),
    .empty_out     (empty_out),
    .full_out      (full_out)
  );

  always #5 clk_in = ~clk_in;

  uop_insn     exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  bit          acc;
  logic [31:0] pc_ctr;
  logic [31:0] base;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare visible head entries against the model, then retire what dispatch consumed.
  always @(negedge clk_in) begin
    if (mon_en && rst_N_in) begin
      int sz;
      int n;
      sz = exp_q.size();
      chk("count_out", count_out, sz);
      chk("empty_out", empty_out, sz == 0);
      chk("full_out", full_out, sz == DEPTH);
      chk("enq_ready_out", enq_ready_out, (DEPTH - sz) >= WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
        chk("deq_valid_out", deq_valid_out[i], i < sz);
        if (i < sz) chk("deq_uop_out", deq_uop_out[i], exp_q[i]);
      end
      if (!flush_in) begin
        n = (int'(deq_num_in) > sz) ? sz : int'(deq_num_in);
        for (int k = 0; k < n; k++) void'(exp_q.pop_front());
      end
    end
  end

  // Drive one cycle of stimulus (called at posedge+1), then fold accepted uops into the model.
  task automatic step(input logic fl, input logic [WIDTH-1:0] v, input int dn);
    flush_in     = fl;
    enq_valid_in = v;
    deq_num_in   = dn[2:0];
    for (int i = 0; i < WIDTH; i++) begin
      enq_uop_in[i].valid = 1'($urandom_range(1, 0));
      enq_uop_in[i].pc    = pc_ctr + 32'(4 * i);
      enq_uop_in[i].insn  = $urandom;
    end
    pc_ctr = pc_ctr + 32'(4 * WIDTH);
    acc = !fl && (v != '0) && ((DEPTH - exp_q.size()) >= WIDTH);
    @(posedge clk_in);
    #1;
    if (fl) exp_q.delete();
    else if (acc) begin
      for (int i = 0; i < WIDTH; i++) if (v[i]) exp_q.push_back(enq_uop_in[i]);
    end
  endtask

  initial begin
    int sz;
    int dn;
    logic fl;
    logic [WIDTH-1:0] v;

    rst_N_in     = 1'b0;
    flush_in     = 1'b0;
    enq_valid_in = '0;
    enq_uop_in   = '0;
    deq_num_in   = '0;
    pc_ctr       = 32'h0000_1000;

    #2;
    chk("rst_count", count_out, 0);
    chk("rst_empty", empty_out, 1);
    chk("rst_full", full_out, 0);
    chk("rst_ready", enq_ready_out, 1);
    chk("rst_deq_valid", deq_valid_out, 0);
    #10;
    rst_N_in = 1'b1;
    @(posedge clk_in);
    #1;
    mon_en = 1'b1;

    // Fill to full; ready must drop once count passes DEPTH-WIDTH.
    for (int g = 1; g <= 8; g++) begin
      step(1'b0, 4'hF, 0);
      chk("fill_ready", enq_ready_out, (4 * g) <= (DEPTH - WIDTH));
    end
    chk("fill_full", full_out, 1);
    step(1'b0, 4'hF, 0);
    chk("overfill_count", count_out, DEPTH);

    // Sparse lanes compact into consecutive slots.
    step(1'b1, 4'h0, 0);
    base = pc_ctr;
    step(1'b0, 4'b1010, 0);
    chk("sparse_valid", deq_valid_out, 4'b0011);
    chk("sparse_pc0", deq_uop_out[0].pc, base + 32'd4);
    chk("sparse_pc1", deq_uop_out[1].pc, base + 32'd12);
    chk("sparse_count", count_out, 2);

    // Steady state across several pointer wraps.
    step(1'b1, 4'h0, 0);
    step(1'b0, 4'hF, 0);
    for (int c = 0; c < 40; c++) begin
      base = pc_ctr;
      step(1'b0, 4'hF, 4);
      chk("steady_count", count_out, 4);
      chk("steady_head_pc", deq_uop_out[0].pc, base);
    end

    // Simultaneous partial dequeue and full enqueue.
    step(1'b1, 4'h0, 0);
    base = pc_ctr;
    step(1'b0, 4'b0111, 0);
    step(1'b0, 4'hF, 2);
    chk("mixed_count", count_out, 5);
    chk("mixed_head_pc", deq_uop_out[0].pc, base + 32'd8);

    // Flush wins over same-cycle enqueue and dequeue.
    step(1'b1, 4'h0, 0);
    repeat (5) step(1'b0, 4'hF, 0);
    chk("preflush_count", count_out, 20);
    step(1'b1, 4'hF, 4);
    chk("flush_count", count_out, 0);
    chk("flush_empty", empty_out, 1);
    chk("flush_deq_valid", deq_valid_out, 0);
    chk("flush_ready", enq_ready_out, 1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      sz = exp_q.size();
      fl = ($urandom_range(39, 0) == 0);
      v  = WIDTH'($urandom);
      dn = $urandom_range((sz < WIDTH) ? sz : WIDTH, 0);
      step(fl, v, dn);
    end

    // Asynchronous reset between edges.
    step(1'b1, 4'h0, 0);
    repeat (3) step(1'b0, 4'hF, 0);
    chk("prereset_count", count_out, 12);
    mon_en       = 1'b0;
    flush_in     = 1'b0;
    enq_valid_in = '0;
    deq_num_in   = '0;
    #2;
    rst_N_in = 1'b0;
    #1;
    chk("async_rst_count", count_out, 0);
    chk("async_rst_deq_valid", deq_valid_out, 0);
    chk("async_rst_empty", empty_out, 1);
    #2;
    rst_N_in = 1'b1;
    exp_q.delete();
    @(posedge clk_in);
    #1;
    mon_en = 1'b1;
    step(1'b0, 4'hF, 0);
    chk("post_rst_count", count_out, 4);
    step(1'b0, 4'h0, 4);
    chk("post_rst_drain", count_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uop_queue.md
Name: uop_queue

Overview:
Decoupling FIFO between decode and rename/ROB dispatch. Accepts up to INSTR_Q_WIDTH uop_insn per cycle from decode and presents up to INSTR_Q_WIDTH oldest entries, in program order, to dispatch. Supports partial dequeue and a full flush on branch mispredict or exception.

Parameters:
DEPTH, uop_pkg::INSTR_Q_DEPTH (32), number of entries; must be a power of 2 and at least 2*WIDTH.
WIDTH, uop_pkg::INSTR_Q_WIDTH (4), enqueue and dequeue lanes per cycle.

Ports:
clk_in  input  1  clock; all state updates on its rising edge.
rst_N_in  input  1  asynchronous, active-low reset.
flush_in  input  1  discards all entries this cycle.
enq_valid_in  input  WIDTH  per-lane valid; lanes may be sparse.
enq_uop_in  input  WIDTH x uop_insn  uops from decode; lane 0 is oldest.
enq_ready_out  output  1  queue can accept a full WIDTH group.
deq_uop_out  output  WIDTH x uop_insn  oldest entries; lane 0 is the head.
deq_valid_out  output  WIDTH  thermometer-coded; lane i is valid iff count > i.
deq_num_in  input  $clog2(WIDTH+1)  number of head entries consumed this cycle.
count_out  output  $clog2(DEPTH+1)  current occupancy.
empty_out  output  1  count == 0.
full_out  output  1  count == DEPTH.

Behaviour:
- Reset (rst_N_in low, asynchronous): head = tail = count = 0. enq_ready_out = 1, deq_valid_out = 0, empty_out = 1, full_out = 0, count_out = 0. Entry storage is not reset. deq_uop_out is don't-care while its valid bit is 0.
- Storage: DEPTH-entry circular array. head and tail pointers are log2(DEPTH) bits and wrap naturally. count is tracked separately, so full and empty are unambiguous.
- enq_ready_out = (DEPTH - count) >= WIDTH. It is computed from registered count only. It does not depend on deq_num_in in the same cycle (no combinational path from deq to enq).
- Enqueue fires when enq_ready_out and at least one enq_valid_in bit are set and flush_in is low:
  - Valid lanes are compacted in lane order into slots tail, tail+1, ... (mod DEPTH).
  - n_enq = popcount(enq_valid_in).
  - tail advances by n_enq.
  - The uop is stored verbatim, including its valid field.
  - If enq_ready_out = 0, inputs are ignored; decode must hold them.
- Dequeue: deq_uop_out[i] = entry[(head+i) mod DEPTH]. This is combinational from registers, so data is visible the cycle after enqueue (1-cycle latency, no bypass).
  - n_deq = min(deq_num_in, count); head advances by n_deq.
  - A simulation assertion fires if deq_num_in > count.
- Simultaneous enqueue and dequeue: count_next = count + n_enq - n_deq. Both use the pre-edge count, so there is no overflow or underflow.
- Wrap-around: compaction and dequeue indexing are both mod DEPTH. A group may straddle entry DEPTH-1 into entry 0.
- Flush: head = tail = count = 0 next cycle. Flush has priority over enqueue and dequeue in the same cycle, and both are dropped. enq_ready_out is 1 the cycle after flush.
- Reset asserted mid-operation clears state immediately, regardless of clock.

Decomposition:
- uop_pkg already holds INSTR_Q_DEPTH, INSTR_Q_WIDTH and uop_insn; reuse them.
- Add to uop_pkg a typedef for the queue pointer (logic [$clog2(INSTR_Q_DEPTH)-1:0]) and one for the count (logic [$clog2(INSTR_Q_DEPTH+1)-1:0]).
- One sub-module, uop_compact: combinational prefix-sum over enq_valid_in. It produces a per-lane slot offset and n_enq, and is reused by future dispatch stages.

Test Plan:
- Reset, then 8 cycles with all enq_valid_in = 4'b1111 and deq_num_in = 0 -> count reaches 32, full_out = 1, enq_ready_out drops after count reaches 29 (it is 0 from count 29 onward); a 9th group is ignored.
- Sparse enqueue enq_valid_in = 4'b1010 with PCs A0/A1/A2/A3 -> next cycle deq_valid_out = 4'b0011, deq_uop_out[0].pc = A1, deq_uop_out[1].pc = A3, count_out = 2.
- Steady state: enqueue 4 and dequeue 4 every cycle for 40 cycles, with PCs incrementing by 4 -> PCs emerge in order across pointer wrap, and count_out stays at 4.
- count = 3 with deq_num_in = 2 and 4 lanes enqueued in the same cycle -> next count_out = 5, and the head is the former third entry.
- count = 20, flush_in = 1 together with enq_valid_in = 4'b1111 and deq_num_in = 4 -> next cycle count_out = 0, empty_out = 1, deq_valid_out = 0, enq_ready_out = 1.
- rst_N_in pulsed low between clock edges with count = 12 -> count_out = 0 and deq_valid_out = 0 immediately, before the next edge.
